round_encrypt_decrypt: RTL and testbench
========================================

# round_encrypt_decrypt

Single-round SPECK128 (64-bit words, α=8, β=3) datapath that applies one encryption round or one decryption round to a 128-bit block under a 64-bit round subkey. It is the round engine underneath the key-schedule/round-sequencer of the SPECK cipher core. The engine runs a small multi-cycle FSM per round and signals completion with a one-cycle `finished` pulse. Decryption is the exact inverse of encryption for the same subkey.

## Interface
- No parameters. Word size 64, block 128, rotations 8/3 are fixed.
- One clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `signal_start` in 1: start request, sampled only in IDLE.
- `mode` in 1: 0 = encrypt, 1 = decrypt; latched with start.
- `subkey` in 64: round key k; latched with start.
- `data_in` in 128: input block; x = [127:64], y = [63:0]; latched with start.
- `data_out` out 128: registered result {x,y}; holds until the next completion.
- `finished` out 1: one-cycle completion pulse.
- `state_response` out 4: current FSM state code.

## Operation
- FSM states (state_response): IDLE=0, S1=1, S2=2, S3=3, DONE=4; codes 5–15 unused and recover to IDLE on the next edge.
- IDLE with signal_start=1: latch x, y, k, mode; go to S1. Start in any other state is ignored.
- Encrypt:
  - S1: x ← ROR8(x) + y (mod 2^64).
  - S2: x ← x ⊕ k.
  - S3: y ← ROL3(y) ⊕ x; data_out ← {x, ROL3(y) ⊕ x}; finished ← 1.
- Decrypt:
  - S1: y ← ROR3(y ⊕ x).
  - S2: x ← x ⊕ k.
  - S3: x ← ROL8(x − y) (mod 2^64); data_out ← {ROL8(x − y), y}; finished ← 1.
- DONE: finished ← 0; go to IDLE.
- All arithmetic is 64-bit unsigned and wraps; carries and borrows are discarded.
- Reset values: state=IDLE, data_out=0, finished=0, internal x/y/k/mode=0.

## Timing
- Start sampled at edge N. State is S1 after N, S2 after N+1, S3 after N+2, DONE after N+3, IDLE after N+4.
- data_out is valid and finished=1 during the cycle after edge N+3 (latency 4 edges). finished is low again after N+4.
- Earliest accepted restart is at edge N+4 (state back in IDLE); throughput is one round per 5 cycles.
- Changes to data_in, subkey or mode after edge N do not affect the running round.
- Reset asserted mid-round: the next edge forces IDLE, finished=0, data_out=0, and discards the round. Reset wins over simultaneous start.
- data_out changes only at S3 (or at reset).

## Configuration
- `ROUND_DECRYPT_EN` defined: the decrypt path is compiled in and `mode` selects the operation.
- `ROUND_DECRYPT_EN` undefined: only the encrypt datapath exists. `mode` is ignored (treated as 0), and state sequence and timing are unchanged.

## Test plan
- Encrypt: data_in={64'h0,64'h1}, k=0 -> after 4 edges data_out={64'h1,64'h9}, finished pulses one cycle, state_response 0→1→2→3→4→0.
- Encrypt: data_in={64'h100,64'h2}, k=64'hFF -> data_out={64'hFC,64'hEC}. Decrypt {64'hFC,64'hEC} with k=64'hFF -> {64'h100,64'h2}.
- Wrap: encrypt {64'h100, 64'hFFFF_FFFF_FFFF_FFFF}, k=0 -> {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}. Decrypt of that block returns the input.
- Round-trip: data_in=128'hab17_0837_7ebc_4ca4_0617_26e2_fcc6_b383, k=64'h2442_2645_2948_404D; encrypt, then decrypt the result -> original block exactly.
- Protocol: hold signal_start high through a whole round -> exactly one round per IDLE visit. Change data_in/subkey mid-round -> result unaffected.
- Reset in S2 -> next cycle state_response=0, finished=0, data_out=0. A subsequent start runs normally.

Source files
------------

// File: rtl/round_encrypt_decrypt_if.sv
// Request/response bundle for the single-round SPECK128 engine.
// Latency: none (wires only).
// Backpressure: none; the requester watches state_response/finished before restarting.
//
// Signals:
//   signal_start   start request, sampled by the engine only while idle
//   mode           0 = encrypt, 1 = decrypt (latched with start)
//   subkey         64-bit round key (latched with start)
//   data_in        128-bit block {x, y} (latched with start)
//   data_out       128-bit registered result {x, y}
//   finished       one-cycle completion pulse
//   state_response current FSM state code
interface round_encrypt_decrypt_if;
  logic         signal_start;
  logic         mode;
  logic [63:0]  subkey;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         finished;
  logic [3:0]   state_response;

  // The requester (round sequencer or bench) drives the request side.
  modport master (
    output signal_start, mode, subkey, data_in,
    input  data_out, finished, state_response
  );

  // The round engine consumes the request and produces the result.
  modport slave (
    input  signal_start, mode, subkey, data_in,
    output data_out, finished, state_response
  );
endinterface

// File: rtl/round_encrypt_decrypt.sv
// One SPECK128 round (alpha=8, beta=3): encrypt, or decrypt when ROUND_DECRYPT_EN is defined.
// Latency: 4 edges from accepted start to data_out/finished; one round per 5 cycles.
// Backpressure: none; start is only sampled in IDLE and ignored in every other state.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    round_encrypt_decrypt_if.slave (start/mode/subkey/data_in in,
//          data_out/finished/state_response out)
// Build option: ROUND_DECRYPT_EN compiles in the decrypt path; without it mode is
// ignored and every round encrypts, with identical state sequence and timing.
module round_encrypt_decrypt (
  input  logic                    clk,
  input  logic                    reset,
  round_encrypt_decrypt_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    S1   = 4'd1,
    S2   = 4'd2,
    S3   = 4'd3,
    DONE = 4'd4
  } state_t;

  state_t       state_q, state_d;
  logic [63:0]  x_q, x_d;
  logic [63:0]  y_q, y_d;
  logic [63:0]  k_q, k_d;
  logic [127:0] dout_q, dout_d;
  logic         fin_q, fin_d;

`ifdef ROUND_DECRYPT_EN
  logic         mode_q, mode_d;
`else
  // Encrypt-only build: mode is accepted on the bus but has no effect.
  logic         mode_unused;
  assign mode_unused = bus.mode;
`endif

  // Fixed rotations of the 64-bit words.
  function automatic logic [63:0] ror8(input logic [63:0] v);
    return {v[7:0], v[63:8]};
  endfunction

  function automatic logic [63:0] rol3(input logic [63:0] v);
    return {v[60:0], v[63:61]};
  endfunction

`ifdef ROUND_DECRYPT_EN
  function automatic logic [63:0] rol8(input logic [63:0] v);
    return {v[55:0], v[63:56]};
  endfunction

  function automatic logic [63:0] ror3(input logic [63:0] v);
    return {v[2:0], v[63:3]};
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      dout_q  <= '0;
      fin_q   <= 1'b0;
`ifdef ROUND_DECRYPT_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      dout_q  <= dout_d;
      fin_q   <= fin_d;
`ifdef ROUND_DECRYPT_EN
      mode_q  <= mode_d;
`endif
    end
  end

  // Next-state and datapath. Every register holds by default; finished is a
  // pulse, so it defaults low and is raised only on the S3 edge.
  always_comb begin
    logic [63:0] y_new;
    logic [63:0] x_new;

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    dout_d  = dout_q;
    fin_d   = 1'b0;
    y_new   = '0;
    x_new   = '0;
`ifdef ROUND_DECRYPT_EN
    mode_d  = mode_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.signal_start) begin
          x_d     = bus.data_in[127:64];
          y_d     = bus.data_in[63:0];
          k_d     = bus.subkey;
`ifdef ROUND_DECRYPT_EN
          mode_d  = bus.mode;
`endif
          state_d = S1;
        end
      end

      S1: begin
`ifdef ROUND_DECRYPT_EN
        if (mode_q) begin
          y_d = ror3(y_q ^ x_q);
        end else begin
          x_d = ror8(x_q) + y_q;
        end
`else
        x_d = ror8(x_q) + y_q;
`endif
        state_d = S2;
      end

      // Key mixing is identical in both directions.
      S2: begin
        x_d     = x_q ^ k_q;
        state_d = S3;
      end

      S3: begin
`ifdef ROUND_DECRYPT_EN
        if (mode_q) begin
          x_new  = rol8(x_q - y_q);
          x_d    = x_new;
          dout_d = {x_new, y_q};
        end else begin
          y_new  = rol3(y_q) ^ x_q;
          y_d    = y_new;
          dout_d = {x_q, y_new};
        end
`else
        y_new  = rol3(y_q) ^ x_q;
        y_d    = y_new;
        dout_d = {x_q, y_new};
`endif
        fin_d   = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      // Unused codes fall back to IDLE on the next edge.
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.data_out       = dout_q;
  assign bus.finished       = fin_q;
  assign bus.state_response = state_q;

endmodule

// File: tb/tb_round_encrypt_decrypt.sv
// Self-checking bench for round_encrypt_decrypt: directed vectors with
// hand-computed results, scoreboard queue filled by the stimulus process and
// drained by a monitor that fires on every finished pulse.
module tb_round_encrypt_decrypt;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  round_encrypt_decrypt_if bus ();

  round_encrypt_decrypt dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int issued = 0;
  int seen = 0;

  logic [127:0] exp_q[$];
  int           id_q[$];
  logic [127:0] mon_exp;
  int           mon_id;

  localparam logic [63:0]  ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] RT_IN  = 128'hab17_0837_7ebc_4ca4_0617_26e2_fcc6_b383;
  localparam logic [63:0]  RT_K   = 64'h2442_2645_2948_404D;
  localparam logic [127:0] RT_ENC = 128'h8e80_1bae_1d0d_2f82_be39_2cb9_fb38_b39a;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge while the engine is idle; returns at the falling
  // edge after the engine is back in IDLE (5 cycles later).
  task automatic do_round(input logic m, input logic [63:0] k, input logic [127:0] d,
                          input logic [127:0] e, input bit chk_states, input bit scramble);
    bus.mode         = m;
    bus.subkey       = k;
    bus.data_in      = d;
    bus.signal_start = 1'b1;
    exp_q.push_back(e);
    id_q.push_back(issued);
    issued++;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.signal_start = 1'b0;
        if (scramble) begin
          bus.data_in = ~d;
          bus.subkey  = ~k;
          bus.mode    = ~m;
        end
      end
      if (chk_states)
        check($sformatf("state_seq_%0d", i), 128'(bus.state_response), 128'((i == 5) ? 0 : i));
    end
  endtask

  // Monitor: every completion pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && bus.finished) begin
      seen++;
      check("finished_in_done", 128'(bus.state_response), 128'(4));
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_finish: got data_out %h, expected no completion", bus.data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_id  = id_q.pop_front();
        check($sformatf("round%0d_data_out", mon_id), bus.data_out, mon_exp);
      end
    end
  end

  initial begin
    bus.signal_start = 1'b0;
    bus.mode         = 1'b0;
    bus.subkey       = '0;
    bus.data_in      = '0;
    reset            = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 128'(bus.state_response), 128'(0));
    check("reset_data_out", bus.data_out, 128'(0));
    check("reset_finished", 128'(bus.finished), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    // Basic encrypt with full state-sequence check.
    do_round(1'b0, 64'h0, {64'h0, 64'h1}, {64'h1, 64'h9}, 1'b1, 1'b0);
    // Encrypt with key.
    do_round(1'b0, 64'hFF, {64'h100, 64'h2}, {64'hFC, 64'hEC}, 1'b0, 1'b0);
    // Carry wrap.
    do_round(1'b0, 64'h0, {64'h100, ONES}, {64'h0, ONES}, 1'b0, 1'b0);
    do_round(1'b0, RT_K, RT_IN, RT_ENC, 1'b0, 1'b0);
`ifdef ROUND_DECRYPT_EN
    do_round(1'b1, 64'hFF, {64'hFC, 64'hEC}, {64'h100, 64'h2}, 1'b1, 1'b0);
    do_round(1'b1, 64'h0, {64'h0, ONES}, {64'h100, ONES}, 1'b0, 1'b0);
    do_round(1'b1, RT_K, RT_ENC, RT_IN, 1'b0, 1'b0);
`else
    // Encrypt-only build: mode=1 still encrypts.
    do_round(1'b1, 64'hFF, {64'hFC, 64'hEC}, {64'hFC00_0000_0000_0013, 64'hFC00_0000_0000_0773}, 1'b1, 1'b0);
    do_round(1'b1, 64'h0, {64'h0, ONES}, {ONES, 64'h0}, 1'b0, 1'b0);
`endif

    // Inputs scrambled right after the start edge must not disturb the round.
    do_round(1'b0, 64'hFF, {64'h100, 64'h2}, {64'hFC, 64'hEC}, 1'b0, 1'b1);

    // Start held high for 10 edges: accepted at the 1st and 6th edge only.
    bus.mode         = 1'b0;
    bus.subkey       = 64'h0;
    bus.data_in      = {64'h0, 64'h1};
    bus.signal_start = 1'b1;
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back({64'h1, 64'h9});
      id_q.push_back(issued);
      issued++;
    end
    repeat (10) @(negedge clk);
    bus.signal_start = 1'b0;
    check("held_start_idle", 128'(bus.state_response), 128'(0));
    @(negedge clk);
    check("held_start_no_third", 128'(bus.state_response), 128'(0));

    // Reset while in S2 discards the round (nothing pushed to the scoreboard).
    bus.mode         = 1'b0;
    bus.subkey       = 64'hFF;
    bus.data_in      = {64'h100, 64'h2};
    bus.signal_start = 1'b1;
    @(negedge clk);
    bus.signal_start = 1'b0;
    @(negedge clk);
    check("pre_reset_s2", 128'(bus.state_response), 128'(2));
    reset = 1'b1;
    bus.signal_start = 1'b1;
    @(negedge clk);
    check("mid_reset_state", 128'(bus.state_response), 128'(0));
    check("mid_reset_finished", 128'(bus.finished), 128'(0));
    check("mid_reset_data_out", bus.data_out, 128'(0));
    reset = 1'b0;
    bus.signal_start = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 128'(bus.state_response), 128'(0));

    do_round(1'b0, 64'h0, {64'h0, 64'h1}, {64'h1, 64'h9}, 1'b1, 1'b0);

    // Drain with a bounded wait.
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    repeat (6) @(negedge clk);
    check("pending_expectations", 128'(exp_q.size()), 128'(0));
    check("completion_count", 128'(seen), 128'(issued));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
